boot_sequencer: RTL and testbench

BOOT_SEQUENCER -- requirements
Module: boot_sequencer

---
 rtl/boot_sequencer.sv | 126 ++++++++++++
 tb/tb_boot_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/boot_sequencer.sv
// boot_sequencer
//   Copies COPY_FIRST..COPY_LAST from EEPROM into RAM, one byte per 4 cycles,
//   then keeps the CPU in reset for HOLD_CYCLES with the bus released, then
//   lets it run. A reboot_req while running restarts the whole copy.
//
// Ports
//   clock        system clock
//   reset_n      async active-low reset; restarts the copy from COPY_FIRST
//   reboot_req   sync request to re-copy; only honoured in RUN
//   address      copy address, meaningful only while bus_own=1
//   bus_own      1 = this block drives address / strobes
//   eeprom_cs_n, eeprom_oe_n, ram_cs_n, ram_we_n   active-low strobes
//   cpu_reset_n  active-low CPU reset, high only in RUN
//   done         copy finished and CPU released
module boot_sequencer #(
  parameter logic [15:0] COPY_FIRST  = 16'hE000,
  parameter logic [15:0] COPY_LAST   = 16'hFFFF,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        reboot_req,
  output logic [15:0] address,
  output logic        bus_own,
  output logic        eeprom_cs_n,
  output logic        eeprom_oe_n,
  output logic        ram_cs_n,
  output logic        ram_we_n,
  output logic        cpu_reset_n,
  output logic        done
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [2:0] {
    COPY_ADDR, COPY_READ, COPY_WRITE, COPY_RELEASE, HANDOFF, RUN
  } state_t;

  state_t          state;
  logic [CW-1:0]   hold_cnt;

  // Outputs are registered: each transition loads the values belonging to
  // the state being entered, so outputs always match the current state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= COPY_ADDR;
      address     <= COPY_FIRST;
      bus_own     <= 1'b1;
      eeprom_cs_n <= 1'b0;
      eeprom_oe_n <= 1'b1;
      ram_cs_n    <= 1'b1;
      ram_we_n    <= 1'b1;
      cpu_reset_n <= 1'b0;
      done        <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      case (state)
        COPY_ADDR: begin
          state       <= COPY_READ;
          eeprom_oe_n <= 1'b0;
        end
        COPY_READ: begin
          state    <= COPY_WRITE;
          ram_cs_n <= 1'b0;
          ram_we_n <= 1'b0;
        end
        COPY_WRITE: begin
          // we_n rises here, a full cycle before the address may move
          state    <= COPY_RELEASE;
          ram_we_n <= 1'b1;
        end
        COPY_RELEASE: begin
          // Compare before incrementing so COPY_LAST=FFFF never wraps to 0000
          if (address != COPY_LAST) begin
            state       <= COPY_ADDR;
            address     <= address + 16'd1;
            eeprom_oe_n <= 1'b1;
            ram_cs_n    <= 1'b1;
          end else begin
            state       <= HANDOFF;
            bus_own     <= 1'b0;
            eeprom_cs_n <= 1'b1;
            eeprom_oe_n <= 1'b1;
            ram_cs_n    <= 1'b1;
            hold_cnt    <= '0;
          end
        end
        HANDOFF: begin
          if (hold_cnt == CW'(HOLD_CYCLES - 1)) begin
            state       <= RUN;
            cpu_reset_n <= 1'b1;
            done        <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          if (reboot_req) begin
            state       <= COPY_ADDR;
            address     <= COPY_FIRST;
            bus_own     <= 1'b1;
            eeprom_cs_n <= 1'b0;
            eeprom_oe_n <= 1'b1;
            ram_cs_n    <= 1'b1;
            ram_we_n    <= 1'b1;
            cpu_reset_n <= 1'b0;
            done        <= 1'b0;
          end
        end
        default: begin
          state       <= COPY_ADDR;
          address     <= COPY_FIRST;
          bus_own     <= 1'b1;
          eeprom_cs_n <= 1'b0;
          eeprom_oe_n <= 1'b1;
          ram_cs_n    <= 1'b1;
          ram_we_n    <= 1'b1;
          cpu_reset_n <= 1'b0;
          done        <= 1'b0;
          hold_cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_sequencer.sv
// Bench for boot_sequencer: three instances (default 8K copy, 64-byte copy
// ending at FFFF, single-byte copy with HOLD_CYCLES=2) share clock and
// inputs. Expected outputs come from the elapsed cycle count since the copy
// started: byte = t/4, phase = t%4, then HOLD cycles of handoff, then run.
module tb_boot_sequencer;

  localparam int NI = 3;
  localparam int FIRST_A [NI] = '{32'hE000, 32'hFFC0, 32'h1234};
  localparam int LAST_A  [NI] = '{32'hFFFF, 32'hFFFF, 32'h1234};
  localparam int HOLD_A  [NI] = '{4, 3, 2};

  logic        clock = 1'b0;
  logic        reset_n;
  logic        reboot_req;
  logic [15:0] addr [NI];
  logic        bo   [NI];
  logic        ecs  [NI];
  logic        eoe  [NI];
  logic        rcs  [NI];
  logic        rwe  [NI];
  logic        cpu  [NI];
  logic        dn   [NI];

  int t [NI];
  int n_chk = 0;
  int n_err = 0;

  // u0 copy bookkeeping
  bit count_en = 0;
  int cyc = 0;
  int wcnt = 0;
  int dup = 0;
  int done_at = -1;
  bit seen [8192];
  int zero_seen = 0;

  always #5 clock = ~clock;

  boot_sequencer u0 (
    .clock(clock), .reset_n(reset_n), .reboot_req(reboot_req),
    .address(addr[0]), .bus_own(bo[0]), .eeprom_cs_n(ecs[0]), .eeprom_oe_n(eoe[0]),
    .ram_cs_n(rcs[0]), .ram_we_n(rwe[0]), .cpu_reset_n(cpu[0]), .done(dn[0]));

  boot_sequencer #(.COPY_FIRST(16'hFFC0), .COPY_LAST(16'hFFFF), .HOLD_CYCLES(3)) u1 (
    .clock(clock), .reset_n(reset_n), .reboot_req(reboot_req),
    .address(addr[1]), .bus_own(bo[1]), .eeprom_cs_n(ecs[1]), .eeprom_oe_n(eoe[1]),
    .ram_cs_n(rcs[1]), .ram_we_n(rwe[1]), .cpu_reset_n(cpu[1]), .done(dn[1]));

  boot_sequencer #(.COPY_FIRST(16'h1234), .COPY_LAST(16'h1234), .HOLD_CYCLES(2)) u2 (
    .clock(clock), .reset_n(reset_n), .reboot_req(reboot_req),
    .address(addr[2]), .bus_own(bo[2]), .eeprom_cs_n(ecs[2]), .eeprom_oe_n(eoe[2]),
    .ram_cs_n(rcs[2]), .ram_we_n(rwe[2]), .cpu_reset_n(cpu[2]), .done(dn[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {address, bus_own, eeprom_cs_n, eeprom_oe_n, ram_cs_n, ram_we_n, cpu_reset_n, done}
  function automatic logic [22:0] model(int first, int last, int hold, int tt);
    int n;
    logic [15:0] a;
    n = last - first + 1;
    if (tt < 4*n) begin
      a = 16'(first + tt/4);
      case (tt % 4)
        0:       return {a, 7'b1_0_1_1_1_0_0};
        1:       return {a, 7'b1_0_0_1_1_0_0};
        2:       return {a, 7'b1_0_0_0_0_0_0};
        default: return {a, 7'b1_0_0_0_1_0_0};
      endcase
    end else if (tt < 4*n + hold) begin
      return {16'h0, 7'b0_1_1_1_1_0_0};
    end
    return {16'h0, 7'b0_1_1_1_1_1_1};
  endfunction

  // Advance each reference by one clock edge using the inputs seen at that edge
  task automatic tick_model();
    for (int i = 0; i < NI; i++) begin
      int tcap;
      tcap = 4*(LAST_A[i] - FIRST_A[i] + 1) + HOLD_A[i];
      if (!reset_n)          t[i] = 0;
      else if (t[i] >= tcap) t[i] = reboot_req ? 0 : tcap;
      else                   t[i] = t[i] + 1;
    end
  endtask

  task automatic check_all(input string ctx);
    for (int i = 0; i < NI; i++) begin
      logic [22:0] e, o;
      e = model(FIRST_A[i], LAST_A[i], HOLD_A[i], t[i]);
      o = {(e[6] ? addr[i] : 16'h0), bo[i], ecs[i], eoe[i], rcs[i], rwe[i], cpu[i], dn[i]};
      chk($sformatf("%s_u%0d_t%0d", ctx, i, t[i]), 32'(o), 32'(e));
      if (bo[i] === 1'b1 && addr[i] == 16'h0000 && i == 1) zero_seen++;
    end
    if (count_en) begin
      if (done_at < 0 && rwe[0] === 1'b0) begin
        logic [15:0] d;
        wcnt++;
        d = addr[0] - 16'hE000;
        if (d >= 16'd8192) dup++;
        else begin
          if (seen[d]) dup++;
          seen[d] = 1'b1;
        end
      end
      if (done_at < 0 && dn[0] === 1'b1) done_at = cyc;
    end
  endtask

  task automatic step();
    @(posedge clock);
    tick_model();
    cyc++;
    @(negedge clock);
    check_all("cyc");
  endtask

  // Reset dropped mid high phase: outputs must change before the next edge
  task automatic async_reset_pulse();
    @(posedge clock);
    tick_model();
    cyc++;
    #2;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) t[i] = 0;
    check_all("async");
    @(negedge clock);
    check_all("rstlow");
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    reboot_req = 1'b0;
    for (int i = 0; i < NI; i++) t[i] = 0;
    repeat (3) step();
    reset_n = 1'b1;

    // Run u0 to byte 100, then reset it mid-copy
    repeat (400) begin
      reboot_req = ($urandom_range(15) == 0);
      step();
    end
    chk("byte100_addr", 32'(addr[0]), 32'hE000 + 100);
    async_reset_pulse();

    // Full default copy; reboot pulses must not disturb u0 while copying
    cyc = 0;
    count_en = 1'b1;
    repeat (32800) begin
      reboot_req = ($urandom_range(15) == 0);
      step();
    end
    count_en = 1'b0;
    chk("u0_writes", 32'(wcnt), 32'd8192);
    chk("u0_dup_or_range", 32'(dup), 32'd0);
    chk("u0_done_cycle", 32'(done_at), 32'd32772);

    // Random reboots and occasional resets
    repeat (3000) begin
      reboot_req = ($urandom_range(7) == 0);
      if ($urandom_range(299) == 0) async_reset_pulse();
      else step();
    end
    reboot_req = 1'b0;
    chk("u1_addr0000", 32'(zero_seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
